icache_ctrl: RTL



---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_array.sv | 51 +++++
 rtl/icache_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_t     : controller FSM states
//   WORD_WIDTH  : width of one cached instruction word
//   addr_index  : line index of a byte address (addr[index_bits+1:2])
//   addr_tag    : tag of a byte address (addr[31:index_bits+2])
package icache_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_START,
    MEM_WAIT,
    RESPOND
  } state_t;

  // Both helpers return a full-width value; callers size-cast to their field width.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned index_bits);
    return addr >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, data and valid storage for the instruction cache.
//   clk, reset   : clock, asynchronous active-low reset (valid bits only)
//   flush        : clears every valid bit at the next edge; beats a write
//   rd_*         : combinational read port addressed by rd_index
//   wr_*         : synchronous write port; a write also sets the line valid
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 16,
  parameter int unsigned INDEX_BITS = $clog2(LINES),
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_WIDTH-1:0] wr_data
);

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [WORD_WIDTH-1:0] data [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
//   clk, reset          : clock, asynchronous active-low reset
//   fetch_req/address   : request from fetch stage, taken only while fetch_ready
//   fetch_ready         : high only in IDLE
//   fetch_valid         : one-cycle pulse with fetch_instruction
//   flush               : invalidate all lines at the next edge
//   memory_*            : SLOW_MEMORY read handshake (start pulse, rdy/data back)
//   memory_write_enable : tied low, the cache never writes memory
// Hit: request edge to fetch_valid is 2 clocks. Miss: memory latency + 3.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 16,
  parameter int unsigned INDEX_BITS = $clog2(LINES),
  parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_address,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [WORD_WIDTH-1:0] fetch_instruction,
  input  logic                  flush,
  output logic [31:0]           memory_address,
  output logic                  memory_start,
  input  logic                  memory_rdy,
  input  logic [WORD_WIDTH-1:0] memory_data,
  output logic                  memory_write_enable
);

  state_t state, state_next;

  logic [29:0]           req_word;
  logic                  fill_killed;
  logic [INDEX_BITS-1:0] line_index;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  fill;
  logic                  unused_byte_offset;

  // Byte offset never matters for word fetches.
  assign unused_byte_offset = ^fetch_address[1:0];

  // The registered request doubles as the memory address, so it stays
  // stable from MEM_START through MEM_WAIT and resets to zero.
  assign memory_address      = {req_word, 2'b00};
  assign memory_write_enable = 1'b0;

  assign line_index = INDEX_BITS'(addr_index(memory_address, INDEX_BITS));
  assign line_tag   = TAG_BITS'(addr_tag(memory_address, INDEX_BITS));
  assign hit        = rd_valid && (rd_tag == line_tag);
  assign fill       = (state == MEM_WAIT) && memory_rdy;

  icache_array #(
    .LINES      (LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rd_index (line_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    // A flush seen during the miss suppresses the fill entirely; a flush on
    // the rdy edge itself is handled inside the array (clear beats set).
    .wr_en    (fill && !fill_killed),
    .wr_index (line_index),
    .wr_tag   (line_tag),
    .wr_data  (memory_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fetch_ready  = 1'b0;
    memory_start = 1'b0;
    case (state)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) state_next = LOOKUP;
      end
      LOOKUP:    state_next = hit ? IDLE : MEM_START;
      MEM_START: begin
        memory_start = 1'b1;
        state_next   = MEM_WAIT;
      end
      MEM_WAIT:  if (memory_rdy) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_word          <= '0;
      fill_killed       <= 1'b0;
      fetch_valid       <= 1'b0;
      fetch_instruction <= '0;
    end else begin
      if (state == IDLE && fetch_req) req_word <= fetch_address[31:2];

      if (state == LOOKUP) begin
        fill_killed <= 1'b0;
      end else if (flush && (state == MEM_START || state == MEM_WAIT)) begin
        fill_killed <= 1'b1;
      end

      // Registered valid pulse: lands in IDLE after a hit, in RESPOND after a fill.
      fetch_valid <= (state == LOOKUP && hit) || fill;
      if (state == LOOKUP && hit) begin
        fetch_instruction <= rd_data;
      end else if (fill) begin
        fetch_instruction <= memory_data;
      end
    end
  end

endmodule
